// File: rtl/master_port.sv
// Serial system-bus master: wins the bus from the arbiter, shifts a latched request out on
// 1-bit lanes (MSB first), and collects read bytes returned by the slave.
module master_port #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 13,
  parameter int unsigned SEL_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [BURST_WIDTH-1:0] burst_num,
  input  logic [SEL_WIDTH-1:0]   slave_select,
  input  logic [1:0]             instruction,
  input  logic                   approval_grant,
  input  logic                   busy,
  input  logic                   slave_ready,
  input  logic                   rx_done,
  input  logic                   slave_valid,
  input  logic                   rx_data,
  output logic                   approval_request,
  output logic                   tx_slave_select,
  output logic                   master_ready,
  output logic                   master_valid,
  output logic                   tx_address,
  output logic                   tx_data,
  output logic                   tx_burst_number,
  output logic                   tx_done,
  output logic                   write_en,
  output logic                   read_en,
  output logic                   new_rx,
  output logic [DATA_WIDTH-1:0]  received_data
);

  localparam int unsigned AddrCycles = (ADDR_WIDTH > BURST_WIDTH) ? ADDR_WIDTH : BURST_WIDTH;
  localparam int unsigned CntMax0    = (AddrCycles > DATA_WIDTH) ? AddrCycles : DATA_WIDTH;
  localparam int unsigned CntMax     = (CntMax0 > SEL_WIDTH) ? CntMax0 : SEL_WIDTH;
  localparam int unsigned CntWidth   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StReq, StSel, StWaitRdy, StAddr, StWdata, StWack, StRdata
  } state_e;

  state_e                 state;
  logic                   is_write_q;
  logic [SEL_WIDTH-1:0]   sel_sh;
  logic [ADDR_WIDTH-1:0]  addr_sh;
  logic [BURST_WIDTH-1:0] burst_sh;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [DATA_WIDTH-1:0]  data_sh;
  logic [DATA_WIDTH-2:0]  rx_sh;
  logic [CntWidth-1:0]    cnt;
  // One extra bit so the largest burst completes without wrapping.
  logic [BURST_WIDTH:0]   beat_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= StIdle;
      is_write_q       <= 1'b0;
      sel_sh           <= '0;
      addr_sh          <= '0;
      burst_sh         <= '0;
      burst_q          <= '0;
      data_sh          <= '0;
      rx_sh            <= '0;
      cnt              <= '0;
      beat_cnt         <= '0;
      approval_request <= 1'b0;
      tx_slave_select  <= 1'b0;
      master_ready     <= 1'b0;
      master_valid     <= 1'b0;
      tx_address       <= 1'b0;
      tx_data          <= 1'b0;
      tx_burst_number  <= 1'b0;
      tx_done          <= 1'b0;
      write_en         <= 1'b0;
      read_en          <= 1'b0;
      new_rx           <= 1'b0;
      received_data    <= '0;
    end else begin
      tx_done <= 1'b0;
      new_rx  <= 1'b0;
      // Losing the grant once the bus is owned drops the transfer silently.
      if (state != StIdle && state != StReq && !approval_grant) begin
        state            <= StIdle;
        approval_request <= 1'b0;
        tx_slave_select  <= 1'b0;
        master_ready     <= 1'b0;
        master_valid     <= 1'b0;
        tx_address       <= 1'b0;
        tx_data          <= 1'b0;
        tx_burst_number  <= 1'b0;
        write_en         <= 1'b0;
        read_en          <= 1'b0;
        received_data    <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (instruction == 2'b01 || instruction == 2'b10) begin
              is_write_q       <= instruction[1];
              sel_sh           <= slave_select;
              addr_sh          <= address;
              burst_sh         <= burst_num;
              burst_q          <= burst_num;
              approval_request <= 1'b1;
              state            <= StReq;
            end
          end
          StReq: begin
            if (approval_grant && !busy) begin
              master_valid    <= 1'b1;
              tx_slave_select <= sel_sh[SEL_WIDTH-1];
              sel_sh          <= sel_sh << 1;
              cnt             <= '0;
              state           <= StSel;
            end
          end
          StSel: begin
            if (cnt == CntWidth'(SEL_WIDTH - 1)) begin
              master_valid    <= 1'b0;
              tx_slave_select <= 1'b0;
              master_ready    <= 1'b1;
              state           <= StWaitRdy;
            end else begin
              cnt             <= cnt + 1'b1;
              tx_slave_select <= sel_sh[SEL_WIDTH-1];
              sel_sh          <= sel_sh << 1;
            end
          end
          StWaitRdy: begin
            if (slave_ready) begin
              master_ready    <= 1'b0;
              master_valid    <= 1'b1;
              tx_address      <= addr_sh[ADDR_WIDTH-1];
              addr_sh         <= addr_sh << 1;
              tx_burst_number <= burst_sh[BURST_WIDTH-1];
              burst_sh        <= burst_sh << 1;
              write_en        <= is_write_q;
              read_en         <= ~is_write_q;
              cnt             <= '0;
              state           <= StAddr;
            end
          end
          StAddr: begin
            if (cnt == CntWidth'(AddrCycles - 1)) begin
              tx_address      <= 1'b0;
              tx_burst_number <= 1'b0;
              cnt             <= '0;
              beat_cnt        <= '0;
              if (is_write_q) begin
                state <= StWdata;
                if (slave_ready) begin
                  tx_data <= data[DATA_WIDTH-1];
                  data_sh <= data << 1;
                end else begin
                  master_valid <= 1'b0;
                end
              end else begin
                master_valid <= 1'b0;
                master_ready <= 1'b1;
                state        <= StRdata;
              end
            end else begin
              cnt             <= cnt + 1'b1;
              tx_address      <= addr_sh[ADDR_WIDTH-1];
              addr_sh         <= addr_sh << 1;
              tx_burst_number <= burst_sh[BURST_WIDTH-1];
              burst_sh        <= burst_sh << 1;
            end
          end
          StWdata: begin
            // master_valid low here means we are parked at a beat boundary.
            if (master_valid && cnt != CntWidth'(DATA_WIDTH - 1)) begin
              cnt     <= cnt + 1'b1;
              tx_data <= data_sh[DATA_WIDTH-1];
              data_sh <= data_sh << 1;
            end else if (master_valid && beat_cnt == {1'b0, burst_q}) begin
              master_valid <= 1'b0;
              tx_data      <= 1'b0;
              tx_done      <= 1'b1;
              state        <= StWack;
            end else begin
              if (master_valid) beat_cnt <= beat_cnt + 1'b1;
              cnt <= '0;
              if (slave_ready) begin
                master_valid <= 1'b1;
                tx_data      <= data[DATA_WIDTH-1];
                data_sh      <= data << 1;
              end else begin
                master_valid <= 1'b0;
                tx_data      <= 1'b0;
              end
            end
          end
          StWack: begin
            if (rx_done) begin
              write_en         <= 1'b0;
              approval_request <= 1'b0;
              state            <= StIdle;
            end
          end
          StRdata: begin
            if (slave_valid) begin
              rx_sh <= {rx_sh[DATA_WIDTH-3:0], rx_data};
              if (cnt == CntWidth'(DATA_WIDTH - 1)) begin
                cnt           <= '0;
                received_data <= {rx_sh, rx_data};
                new_rx        <= 1'b1;
                if (beat_cnt == {1'b0, burst_q}) begin
                  tx_done          <= 1'b1;
                  read_en          <= 1'b0;
                  master_ready     <= 1'b0;
                  approval_request <= 1'b0;
                  state            <= StIdle;
                end else begin
                  beat_cnt <= beat_cnt + 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: expected lane bits, read bytes and done pulses are queued
// at issue time from the request fields; a negedge monitor pops and compares them.
module tb_master_port;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int BW   = 13;
  localparam int SW   = 3;
  localparam int ACYC = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data;
  logic [BW-1:0] burst_num = '0;
  logic [SW-1:0] slave_select = '0;
  logic [1:0]    instruction = 2'b00;
  logic          approval_grant = 1'b0;
  logic          busy = 1'b0;
  logic          slave_ready = 1'b0;
  logic          rx_done = 1'b0;
  logic          slave_valid = 1'b0;
  logic          rx_data = 1'b0;
  logic          approval_request, tx_slave_select, master_ready, master_valid;
  logic          tx_address, tx_data, tx_burst_number, tx_done, write_en, read_en, new_rx;
  logic [DW-1:0] received_data;

  master_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data(data), .burst_num(burst_num),
    .slave_select(slave_select), .instruction(instruction), .approval_grant(approval_grant),
    .busy(busy), .slave_ready(slave_ready), .rx_done(rx_done), .slave_valid(slave_valid),
    .rx_data(rx_data), .approval_request(approval_request), .tx_slave_select(tx_slave_select),
    .master_ready(master_ready), .master_valid(master_valid), .tx_address(tx_address),
    .tx_data(tx_data), .tx_burst_number(tx_burst_number), .tx_done(tx_done),
    .write_en(write_en), .read_en(read_en), .new_rx(new_rx), .received_data(received_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sel; logic adr; logic bur; logic dat; logic wr; logic rd; bit first;
  } lane_t;

  lane_t         tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] wbeat_q[$];
  logic [DW-1:0] pick_q[$];
  logic          rx_bits[$];
  int            n_checks = 0;
  int            n_fails = 0;
  int            done_pending = 0;
  int            done_seen = 0;
  int            newrx_seen = 0;
  int            rdy_mode = 0;
  logic          done_prev = 1'b0;
  lane_t         mon_e;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic lane_t lane(input logic s, input logic a, input logic b, input logic d,
                                 input logic wr, input logic rd, input bit f);
    lane_t e;
    e.sel = s; e.adr = a; e.bur = b; e.dat = d; e.wr = wr; e.rd = rd; e.first = f;
    return e;
  endfunction

  // Reference model: bit stream implied by the request fields.
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [SW-1:0] s,
                       input logic [BW-1:0] b, input bit expect_done);
    logic [DW-1:0] d;
    for (int i = SW - 1; i >= 0; i--) tx_q.push_back(lane(s[i], 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < ACYC; c++)
      tx_q.push_back(lane(0, (c < AW) ? a[AW-1-c] : 1'b0, (c < BW) ? b[BW-1-c] : 1'b0, 0,
                          wr, !wr, 0));
    for (int k = 0; k <= int'(b); k++) begin
      d = (pick_q.size() != 0) ? pick_q.pop_front() : DW'($urandom);
      if (wr) begin
        wbeat_q.push_back(d);
        for (int i = DW - 1; i >= 0; i--)
          tx_q.push_back(lane(0, 0, 0, d[i], 1, 0, i == DW - 1));
      end else begin
        rx_q.push_back(d);
        for (int i = DW - 1; i >= 0; i--) rx_bits.push_back(d[i]);
      end
    end
    if (expect_done) done_pending++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit wr, input logic [AW-1:0] a, input logic [SW-1:0] s,
                       input logic [BW-1:0] b, input bit expect_done);
    issue(wr, a, s, b, expect_done);
    instruction = wr ? 2'b10 : 2'b01;
    address = a; slave_select = s; burst_num = b;
    tick();
    // Later request-field changes must not leak into the latched transfer.
    instruction = ($urandom_range(1) != 0) ? 2'b11 : 2'b00;
    address = AW'($urandom); slave_select = SW'($urandom); burst_num = BW'($urandom);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 3000 && done_pending != 0; k++) tick();
    chkn(name, done_pending, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chkn(name, {approval_request, tx_slave_select, master_ready, master_valid, tx_address,
                tx_data, tx_burst_number, tx_done, write_en, read_en, new_rx}, 0);
    chkn({name, " received_data"}, 32'(received_data), 0);
  endtask

  always @(posedge clk) begin
    case (rdy_mode)
      0:       slave_ready <= 1'b0;
      1:       slave_ready <= 1'b1;
      default: slave_ready <= ($urandom_range(3) != 0);
    endcase
  end

  always @(posedge clk) begin
    if (read_en && master_ready && rx_bits.size() != 0 && $urandom_range(3) != 0) begin
      slave_valid <= 1'b1;
      rx_data     <= rx_bits.pop_front();
    end else begin
      slave_valid <= 1'b0;
      rx_data     <= 1'($urandom);
    end
  end

  always @(negedge clk) begin
    if (master_valid) begin
      chk1("tx valid expected", tx_q.size() != 0, 1'b1);
      if (tx_q.size() != 0) begin
        mon_e = tx_q.pop_front();
        chk1("tx_slave_select", tx_slave_select, mon_e.sel);
        chk1("tx_address", tx_address, mon_e.adr);
        chk1("tx_burst_number", tx_burst_number, mon_e.bur);
        chk1("tx_data", tx_data, mon_e.dat);
        chk1("write_en", write_en, mon_e.wr);
        chk1("read_en", read_en, mon_e.rd);
        if (mon_e.first && wbeat_q.size() != 0) void'(wbeat_q.pop_front());
      end
    end
    if (new_rx) begin
      newrx_seen++;
      chk1("new_rx expected", rx_q.size() != 0, 1'b1);
      if (rx_q.size() != 0) chkn("received_data", 32'(received_data), 32'(rx_q.pop_front()));
    end
    if (tx_done) begin
      done_seen++;
      chk1("tx_done expected", done_pending > 0, 1'b1);
      chk1("tx_done single pulse", done_prev, 1'b0);
      if (done_pending > 0) done_pending--;
    end
    done_prev = tx_done;
    data = (wbeat_q.size() != 0) ? wbeat_q[0] : '0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int nrx;
    bit wr;
    repeat (3) tick();
    chk_all_zero("reset state");
    reset = 1'b1;
    tick();

    // Directed write: request held off by grant, then busy; slave 101, address 0xADD.
    pick_q.push_back(8'hFF);
    start(1, 12'hADD, 3'b101, 13'd0, 1);
    chk1("request raised", approval_request, 1'b1);
    chkn("lanes idle in request", {master_valid, tx_slave_select, tx_address, tx_data,
                                   tx_burst_number}, 0);
    repeat (2) begin
      tick();
      chk1("request held without grant", approval_request, 1'b1);
    end
    approval_grant = 1'b1;
    busy = 1'b1;
    repeat (3) begin
      tick();
      chk1("no select while busy", master_valid, 1'b0);
    end
    busy = 1'b0;
    tick();
    chk1("select starts after busy", master_valid, 1'b1);
    for (int k = 0; k < 10 && !master_ready; k++) tick();
    repeat (4) begin
      chk1("master_ready while waiting", master_ready, 1'b1);
      chk1("no valid while waiting", master_valid, 1'b0);
      tick();
    end
    rdy_mode = 1;
    wait_done("write done");
    chk1("write_en held for ack", write_en, 1'b1);
    chk1("request held for ack", approval_request, 1'b1);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk1("write released request", approval_request, 1'b0);
    chk1("write_en cleared", write_en, 1'b0);

    // Directed read: two bytes 0xA5 then 0x3C.
    pick_q.push_back(8'hA5);
    pick_q.push_back(8'h3C);
    nrx = newrx_seen;
    start(0, AW'($urandom), SW'($urandom), 13'd1, 1);
    wait_done("read done");
    chkn("new_rx count", newrx_seen - nrx, 2);
    chkn("last read byte", 32'(received_data), 32'h3C);
    chk1("read_en cleared", read_en, 1'b0);
    chk1("read released request", approval_request, 1'b0);

    // Grant dropped partway through the address phase.
    d0 = done_seen;
    start(1, AW'($urandom), SW'($urandom), 13'd2, 0);
    for (int k = 0; k < 200 && tx_q.size() > SW + ACYC + 3 * DW - 8; k++) tick();
    approval_grant = 1'b0;
    tick();
    chk_all_zero("abort");
    tx_q.delete();
    wbeat_q.delete();
    approval_grant = 1'b1;
    repeat (3) tick();
    chkn("no tx_done on abort", done_seen - d0, 0);

    // Asynchronous reset in the middle of a read.
    start(0, AW'($urandom), SW'($urandom), 13'd0, 1);
    for (int k = 0; k < 100 && !read_en; k++) tick();
    chk1("read address phase reached", read_en, 1'b1);
    #1 reset = 1'b0;
    #1 chk_all_zero("async reset");
    tx_q.delete();
    rx_q.delete();
    rx_bits.delete();
    done_pending = 0;
    tick();
    reset = 1'b1;
    tick();

    // Random transfers with random grant/busy hold-off and slave stalls.
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      wr = ($urandom_range(1) != 0);
      approval_grant = ($urandom_range(1) != 0);
      busy = ($urandom_range(1) != 0);
      start(wr, AW'($urandom), SW'($urandom), BW'($urandom_range(3)), 1);
      repeat ($urandom_range(3)) tick();
      approval_grant = 1'b1;
      busy = 1'b0;
      wait_done("random done");
      if (wr) begin
        repeat ($urandom_range(2)) tick();
        chk1("random write_en before ack", write_en, 1'b1);
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
      end
      chk1("random request released", approval_request, 1'b0);
      chkn("random enables cleared", {write_en, read_en}, 0);
    end

    tick();
    chkn("lanes left unchecked", tx_q.size(), 0);
    chkn("read bytes left unchecked", rx_q.size(), 0);
    chkn("done pulses outstanding", done_pending, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/master_port.md
Name: master_port

Overview:
- Bus-side master interface for the serial system bus.
- Accepts a parallel transaction request (instruction, slave select, address, burst count, write data) from the local core.
- Obtains bus ownership from the arbiter, then serializes slave select, address, burst count and write data onto 1-bit lanes.
- For reads, deserializes returned bytes and flags each completed byte.

Parameters:
- ADDR_WIDTH, 12, address bits sent per transaction
- DATA_WIDTH, 8, bits per data beat
- BURST_WIDTH, 13, burst-count bits; beats = burst_num+1
- SEL_WIDTH, 3, slave-select bits

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- address  in  ADDR_WIDTH  transaction address
- data  in  DATA_WIDTH  write data
- burst_num  in  BURST_WIDTH  beats minus one
- slave_select  in  SEL_WIDTH  target slave id
- instruction  in  2  00 idle, 01 read, 10 write, 11 reserved (treated as idle)
- approval_grant  in  1  arbiter grant
- busy  in  1  bus occupied; hold off while high
- slave_ready  in  1  slave ready to accept address/data
- rx_done  in  1  slave acknowledge of completed write
- slave_valid  in  1  rx_data bit valid this cycle
- rx_data  in  1  serial read data, MSB first
- approval_request  out  1  bus request to arbiter
- tx_slave_select  out  1  serial slave id, MSB first
- master_ready  out  1  master ready / waiting for slave
- master_valid  out  1  serial tx lanes carry valid bits
- tx_address  out  1  serial address, MSB first
- tx_data  out  1  serial write data, MSB first
- tx_burst_number  out  1  serial burst count, MSB first
- tx_done  out  1  one-cycle end-of-transaction pulse
- write_en  out  1  write transaction in progress
- read_en  out  1  read transaction in progress
- new_rx  out  1  one-cycle pulse: read byte complete
- received_data  out  DATA_WIDTH  last completed read byte

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; received_data 0; all latches cleared.
- IDLE: when instruction is 01 or 10, latch instruction, address, burst_num and slave_select; go REQ. Data is latched per write beat.
- REQ: approval_request=1. approval_request stays 1 until return to IDLE. Wait for approval_grant=1 && busy=0 on a rising edge, then go SEL.
- SEL: SEL_WIDTH cycles; tx_slave_select = latched slave_select MSB first; master_valid=1.
- WAIT_RDY: master_ready=1; wait for slave_ready=1.
- ADDR: master_valid=1 for max(ADDR_WIDTH, BURST_WIDTH) = 13 cycles.
  - tx_address shifts address MSB first; it is 0 after bit 0.
  - tx_burst_number shifts burst_num MSB first concurrently.
  - write_en or read_en is asserted from ADDR onward per the latched instruction.
- WDATA (write): per beat, sample data at beat start, then shift DATA_WIDTH bits on tx_data with master_valid=1.
  - If slave_ready=0 at a beat boundary, pause (master_valid=0) until it returns.
  - After beat burst_num+1: pulse tx_done 1 cycle, go WACK.
- WACK: wait for rx_done=1, then go IDLE and clear write_en.
- RDATA (read): master_ready=1.
  - Each cycle with slave_valid=1, shift rx_data into an LSB-entering shift register.
  - After DATA_WIDTH valid bits: update received_data and pulse new_rx for the cycle after the last bit.
  - After burst_num+1 bytes: pulse tx_done, go IDLE, clear read_en.
- Abort: approval_grant=0 in any state after REQ returns to IDLE next edge with all outputs cleared, without a tx_done pulse.
- instruction changes after latching are ignored until IDLE.
- A reset assertion mid-transfer clears everything immediately.
- Burst counter is BURST_WIDTH+1 bits, so burst_num=8191 gives 8192 beats with no wrap.

Test Plan:
- Reset at start, then instruction=10 with grant=0 → approval_request=1 within 1 cycle; all tx lanes 0, master_valid=0.
- Grant=1 with busy=1 for 3 cycles, then busy=0 → SEL starts only after busy falls; tx_slave_select emits 1,0,1 for slave_select=101.
- slave_ready held 0 for 4 cycles, then 1 → master_ready=1 while waiting; then tx_address emits 101011011101 (0xADD) MSB first, and tx_burst_number emits 13 zeros with write_en=1.
- Write, burst_num=0, data=0xFF → tx_data eight 1s; tx_done single pulse; rx_done=1 → IDLE, approval_request=0.
- Read, burst_num=1, slave_valid=1 with serial bits 0xA5 then 0x3C → new_rx pulses twice, received_data=0xA5 then 0x3C, tx_done pulse, read_en drops.
- Grant dropped mid-address phase → IDLE next cycle, all outputs 0, no tx_done; a new request is then accepted normally.
